run_frame_arbiter: RTL

Controller that shares a single consecutive-ones run detector between two serial bit requesters. It grants each requester a fixed-length frame in round-robin order and drives the granted requester's bit through a saturating run-length state machine. It pulses `hit` when a run of ones reaches `RUN_LEN`, and keeps a saturating hit counter per requester. It sits between the serial stimulus sources and the lab's run-detect datapath, and sequences it frame by frame.

---
 rtl/run_frame_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/run_frame_arbiter.sv
// run_frame_arbiter: round-robin frame arbiter that shares one consecutive-ones
// run detector between two serial requesters, with per-requester saturating hit counters.
module run_frame_arbiter #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned RUN_LEN   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       req,
  input  logic             bit_in0,
  input  logic             bit_in1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             hit_id,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic [2:0]       run_state
);

  localparam int unsigned SMP_W = 8;
  localparam int unsigned RUN_W = 3;

  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(FRAME_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SMP_W-1:0] smp_cnt, smp_cnt_nx;
  logic             last, last_nx;
  logic [1:0]       gnt_nx;
  logic             busy_nx, done_nx, hit_nx, hit_id_nx;
  logic [CNT_W-1:0] hit_cnt0_nx, hit_cnt1_nx;
  logic [RUN_W-1:0] run_nx;
  logic             win;
  logic             bit_s;

  // State and registered outputs; last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      last      <= 1'b1;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_id    <= 1'b0;
      hit_cnt0  <= '0;
      hit_cnt1  <= '0;
      run_state <= '0;
    end else begin
      state     <= state_nx;
      smp_cnt   <= smp_cnt_nx;
      last      <= last_nx;
      gnt       <= gnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      hit       <= hit_nx;
      hit_id    <= hit_id_nx;
      hit_cnt0  <= hit_cnt0_nx;
      hit_cnt1  <= hit_cnt1_nx;
      run_state <= run_nx;
    end
  end

  // Next-state, arbitration, run tracking and hit/counter update
  always_comb begin
    state_nx    = state;
    smp_cnt_nx  = smp_cnt;
    last_nx     = last;
    gnt_nx      = gnt;
    hit_nx      = 1'b0;
    hit_id_nx   = hit_id;
    hit_cnt0_nx = hit_cnt0;
    hit_cnt1_nx = hit_cnt1;
    run_nx      = run_state;
    win         = 1'b0;
    bit_s       = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          win        = (req == 2'b11) ? ~last : req[1];
          gnt_nx     = win ? 2'b10 : 2'b01;
          smp_cnt_nx = '0;
          run_nx     = '0;
          state_nx   = RUN;
        end
      end
      RUN: begin
        bit_s      = gnt[1] ? bit_in1 : bit_in0;
        smp_cnt_nx = smp_cnt + SMP_W'(1);
        if (!bit_s) begin
          run_nx = '0;
        end else if (run_state < RUN_MAX) begin
          run_nx = run_state + RUN_W'(1);
        end
        // Hit only on the transition into saturation, so a long run fires once
        if (bit_s && (run_state == RUN_PRE)) begin
          hit_nx    = 1'b1;
          hit_id_nx = gnt[1];
          if (gnt[1]) begin
            if (hit_cnt1 != CNT_MAX) hit_cnt1_nx = hit_cnt1 + CNT_ONE;
          end else begin
            if (hit_cnt0 != CNT_MAX) hit_cnt0_nx = hit_cnt0 + CNT_ONE;
          end
        end
        if (smp_cnt == LAST_SMP) begin
          state_nx = DONE;
          gnt_nx   = 2'b00;
          last_nx  = gnt[1];
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 2'b00;
      end
    endcase

    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

endmodule
